// File: rtl/weight_interface_fanout_if.sv
// rtl/weight_interface_fanout_if.sv - command-in / per-consumer-out bus bundle for the weight fanout
interface weight_interface_fanout_if #(
    parameter int NUM_OUT = 4,
    parameter int IDX_W   = 32,
    parameter int CNT_W   = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     is_load;
    logic [IDX_W-1:0]         w_row_index;
    logic [IDX_W-1:0]         w_layer_index;
    logic [NUM_OUT-1:0]       out_valid;
    logic [NUM_OUT-1:0]       out_ready;
    logic [NUM_OUT-1:0]       is_load_out;
    logic [NUM_OUT*IDX_W-1:0] w_row_index_out;
    logic [NUM_OUT*IDX_W-1:0] w_layer_index_out;
    logic [CNT_W-1:0]         load_count;
    logic                     range_err;

    modport slave (
        input  in_valid, is_load, w_row_index, w_layer_index, out_ready,
        output in_ready, out_valid, is_load_out, w_row_index_out, w_layer_index_out,
               load_count, range_err
    );

    modport master (
        output in_valid, is_load, w_row_index, w_layer_index, out_ready,
        input  in_ready, out_valid, is_load_out, w_row_index_out, w_layer_index_out,
               load_count, range_err
    );
endinterface

// File: rtl/weight_interface_fanout.sv
// rtl/weight_interface_fanout.sv - registered fork of one weight command to NUM_OUT consumers
// Optional range check enabled by defining WEIGHT_FANOUT_BOUND_CHECK_EN.
module weight_interface_fanout #(
    parameter int NUM_OUT   = 4,
    parameter int IDX_W     = 32,
    parameter int CNT_W     = 16,
    parameter int MAX_ROW   = 1024,
    parameter int MAX_LAYER = 16
) (
    input logic                      clk,
    input logic                      reset,
    weight_interface_fanout_if.slave bus
);
    logic [NUM_OUT-1:0] r_pending;
    logic               r_load;
    logic [IDX_W-1:0]   r_row;
    logic [IDX_W-1:0]   r_layer;
    logic [CNT_W-1:0]   r_count;
    logic               w_in_ready;
    logic               w_xfer;
    logic               w_oob;

    // Ready only once every still-pending consumer is taking the current copy.
    assign w_in_ready = ~|(r_pending & ~bus.out_ready);
    assign w_xfer     = bus.in_valid & w_in_ready;

`ifdef WEIGHT_FANOUT_BOUND_CHECK_EN
    localparam logic [IDX_W-1:0] ROW_LIM   = IDX_W'(MAX_ROW);
    localparam logic [IDX_W-1:0] LAYER_LIM = IDX_W'(MAX_LAYER);
    logic r_range_err;

    assign w_oob = (bus.w_row_index >= ROW_LIM) || (bus.w_layer_index >= LAYER_LIM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_range_err <= 1'b0;
        end else if (w_xfer && w_oob) begin
            r_range_err <= 1'b1;
        end
    end

    assign bus.range_err = r_range_err;
`else
    assign w_oob         = 1'b0;
    assign bus.range_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_load    <= 1'b0;
            r_row     <= '0;
            r_layer   <= '0;
            r_count   <= '0;
        end else if (w_xfer) begin
            if (w_oob) begin
                r_pending <= '0;
            end else begin
                r_pending <= '1;
                r_load    <= bus.is_load;
                r_row     <= bus.w_row_index;
                r_layer   <= bus.w_layer_index;
                if (bus.is_load && (r_count != {CNT_W{1'b1}})) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end else begin
            r_pending <= r_pending & ~bus.out_ready;
        end
    end

    assign bus.in_ready          = w_in_ready;
    assign bus.out_valid         = r_pending;
    assign bus.is_load_out       = {NUM_OUT{r_load}};
    assign bus.w_row_index_out   = {NUM_OUT{r_row}};
    assign bus.w_layer_index_out = {NUM_OUT{r_layer}};
    assign bus.load_count        = r_count;
endmodule

// File: tb/tb_weight_interface_fanout.sv
// tb/tb_weight_interface_fanout.sv - directed self-checking bench for weight_interface_fanout
module tb_weight_interface_fanout;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    weight_interface_fanout_if #(.NUM_OUT(4), .IDX_W(32), .CNT_W(16)) bus ();
    weight_interface_fanout_if #(.NUM_OUT(4), .IDX_W(32), .CNT_W(2))  sat ();

    weight_interface_fanout #(.NUM_OUT(4), .IDX_W(32), .CNT_W(16), .MAX_ROW(1024), .MAX_LAYER(16))
        u_dut (.clk(clk), .reset(reset), .bus(bus));
    weight_interface_fanout #(.NUM_OUT(4), .IDX_W(32), .CNT_W(2), .MAX_ROW(1024), .MAX_LAYER(16))
        u_sat (.clk(clk), .reset(reset), .bus(sat));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic ld, input logic [31:0] row, input logic [31:0] layer);
        bus.in_valid      = v;
        bus.is_load       = ld;
        bus.w_row_index   = row;
        bus.w_layer_index = layer;
    endtask

    logic [31:0] row_v;
    logic [31:0] layer_v;
    logic [7:0]  load_pat;

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        bus.out_ready     = 4'b0000;
        sat.in_valid      = 1'b0;
        sat.is_load       = 1'b0;
        sat.w_row_index   = 32'd0;
        sat.w_layer_index = 32'd0;
        sat.out_ready     = 4'b1111;
        #2;
        check("rst_out_valid", bus.out_valid, 4'b0000);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_count", bus.load_count, 16'd0);
        check("rst_row", bus.w_row_index_out, 128'd0);
        check("rst_range_err", bus.range_err, 1'b0);
        tick();
        reset = 1'b0;

        // 1: single command, all consumers ready
        drive(1'b1, 1'b1, 32'd5, 32'd2);
        bus.out_ready = 4'b1111;
        #1;
        check("t1_in_ready", bus.in_ready, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        check("t1_out_valid", bus.out_valid, 4'b1111);
        check("t1_row", bus.w_row_index_out, {4{32'd5}});
        check("t1_layer", bus.w_layer_index_out, {4{32'd2}});
        check("t1_is_load", bus.is_load_out, 4'b1111);
        check("t1_count", bus.load_count, 16'd1);
        tick();
        check("t1_one_cycle", bus.out_valid, 4'b0000);

        // 2: staggered ready with the next command held valid
        bus.out_ready = 4'b0000;
        drive(1'b1, 1'b0, 32'd7, 32'd3);
        tick();
        drive(1'b1, 1'b1, 32'd9, 32'd1);
        bus.out_ready = 4'b0001;
        #1;
        check("t2_pend_1111", bus.out_valid, 4'b1111);
        check("t2_rdy_lo_a", bus.in_ready, 1'b0);
        tick();
        bus.out_ready = 4'b0110;
        #1;
        check("t2_pend_1110", bus.out_valid, 4'b1110);
        check("t2_rdy_lo_b", bus.in_ready, 1'b0);
        check("t2_row_held", bus.w_row_index_out, {4{32'd7}});
        tick();
        bus.out_ready = 4'b1000;
        #1;
        check("t2_pend_1000", bus.out_valid, 4'b1000);
        check("t2_rdy_hi", bus.in_ready, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        bus.out_ready = 4'b0000;
        check("t2_next_valid", bus.out_valid, 4'b1111);
        check("t2_next_row", bus.w_row_index_out, {4{32'd9}});
        check("t2_count", bus.load_count, 16'd2);
        tick();
        check("t2_hold", bus.out_valid, 4'b1111);
        bus.out_ready = 4'b1111;
        tick();
        check("t2_drained", bus.out_valid, 4'b0000);

        // 3: back-to-back streaming, loads in pattern 1011_0110 (five loads)
        load_pat = 8'b1011_0110;
        for (int i = 0; i < 8; i++) begin
            row_v   = 32'(i * 3 + 1);
            layer_v = 32'(i);
            drive(1'b1, load_pat[i], row_v, layer_v);
            #1;
            check("t3_in_ready", bus.in_ready, 1'b1);
            tick();
            check("t3_valid", bus.out_valid, 4'b1111);
            check("t3_row", bus.w_row_index_out, {4{row_v}});
            check("t3_layer", bus.w_layer_index_out, {4{layer_v}});
            check("t3_is_load", bus.is_load_out, {4{load_pat[i]}});
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        check("t3_count", bus.load_count, 16'd7);
        tick();
        check("t3_idle", bus.out_valid, 4'b0000);

        // 4: two-bit counter saturates at 3
        sat.in_valid = 1'b1;
        sat.is_load  = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("t4_sat_count", sat.load_count, (i > 3) ? 2'd3 : 2'(i));
        end
        sat.in_valid = 1'b0;
        tick();
        check("t4_sat_hold", sat.load_count, 2'd3);

        // 5: asynchronous reset while pending = 0101
        bus.out_ready = 4'b0000;
        drive(1'b1, 1'b1, 32'd11, 32'd4);
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        bus.out_ready = 4'b1010;
        tick();
        bus.out_ready = 4'b0000;
        check("t5_pend_0101", bus.out_valid, 4'b0101);
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_valid", bus.out_valid, 4'b0000);
        check("t5_async_row", bus.w_row_index_out, 128'd0);
        check("t5_async_count", bus.load_count, 16'd0);
        check("t5_async_rdy", bus.in_ready, 1'b1);
        check("t5_sat_cleared", sat.load_count, 2'd0);
        tick();
        reset = 1'b0;
        tick();
        check("t5_no_replay_a", bus.out_valid, 4'b0000);
        tick();
        check("t5_no_replay_b", bus.out_valid, 4'b0000);

        // 6: row at the exclusive bound, then an in-range row
        bus.out_ready = 4'b1111;
        drive(1'b1, 1'b1, 32'd1024, 32'd0);
        #1;
        check("t6_in_ready", bus.in_ready, 1'b1);
        tick();
        drive(1'b1, 1'b1, 32'd3, 32'd1);
`ifdef WEIGHT_FANOUT_BOUND_CHECK_EN
        check("t6_oob_valid", bus.out_valid, 4'b0000);
        check("t6_oob_err", bus.range_err, 1'b1);
        check("t6_oob_count", bus.load_count, 16'd0);
        check("t6_oob_row", bus.w_row_index_out, 128'd0);
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        check("t6_ok_valid", bus.out_valid, 4'b1111);
        check("t6_ok_row", bus.w_row_index_out, {4{32'd3}});
        check("t6_err_sticky", bus.range_err, 1'b1);
        check("t6_ok_count", bus.load_count, 16'd1);
`else
        check("t6_nochk_valid", bus.out_valid, 4'b1111);
        check("t6_nochk_row", bus.w_row_index_out, {4{32'd1024}});
        check("t6_nochk_err", bus.range_err, 1'b0);
        check("t6_nochk_count", bus.load_count, 16'd1);
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        check("t6_next_row", bus.w_row_index_out, {4{32'd3}});
        check("t6_next_count", bus.load_count, 16'd2);
        check("t6_err_zero", bus.range_err, 1'b0);
`endif
        tick();
        check("t6_idle", bus.out_valid, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/weight_interface_fanout.md
Name: weight_interface_fanout

Overview:
- Registered, parametrised successor to the combinational weight-interface spreader.
- Broadcasts one weight-interface command (is_load, row index, layer index) to NUM_OUT downstream consumers, with a valid/ready fork handshake.
- A command is retired only after every consumer has accepted it.
- Sits between the weight loader and the per-neuron-column weight memories; adds one register stage to break long fanout paths.

Parameters:
- NUM_OUT, 4, number of consumer ports (>=1).
- IDX_W, 32, width of row and layer index.
- CNT_W, 16, width of the load counter.
- MAX_ROW, 1024, exclusive row bound (used only with BOUND_CHECK_EN).
- MAX_LAYER, 16, exclusive layer bound (used only with BOUND_CHECK_EN).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  command present.
- in_ready  output  1  command accepted this cycle when in_valid is also high.
- is_load  input  1  load strobe of the command.
- w_row_index  input  IDX_W  row index.
- w_layer_index  input  IDX_W  layer index.
- out_valid  output  NUM_OUT  per-consumer valid.
- out_ready  input  NUM_OUT  per-consumer ready.
- is_load_out  output  NUM_OUT  per-consumer copy of is_load.
- w_row_index_out  output  NUM_OUT*IDX_W  flattened per-consumer row copies; consumer k at bits [k*IDX_W +: IDX_W].
- w_layer_index_out  output  NUM_OUT*IDX_W  flattened per-consumer layer copies, same packing.
- load_count  output  CNT_W  number of broadcast commands with is_load=1.
- range_err  output  1  sticky out-of-range flag.

Behaviour:
- **State:** pending[NUM_OUT] mask plus data register (load_r, row_r, layer_r).
  - pending==0 is IDLE; pending!=0 is BUSY.
- **Outputs:**
  - out_valid = pending.
  - All per-consumer data copies are driven from the data register and change only on transfer.
- **in_ready:** in_ready = ~|(pending & ~out_ready).
  - High when IDLE, or when all still-pending consumers accept this cycle.
  - Combinational path from out_ready to in_ready is intentional.
- **Transfer:** occurs when in_valid & in_ready.
  - Data register <= inputs.
  - pending <= all ones.
  - A new command overwrites the one draining in the same cycle, so there is no bubble.
- **No transfer:** pending <= pending & ~out_ready.
  - Consumers drop out independently, in any order and in any cycle.
- **Latency and throughput:**
  - Latency is 1 cycle from input transfer to out_valid.
  - Throughput is 1 command/cycle when all out_ready are held high.
- **Holding data:** out_valid[k] stays high with stable data until out_ready[k].
  - Deasserting out_ready never loses a command.
- **load_count:**
  - +1 on each broadcast transfer with is_load=1.
  - Saturates at all ones; no wrap.
- **Reset (async, active-high):**
  - pending=0, data register=0, load_count=0, range_err=0.
  - Hence out_valid=0, all data outputs 0, in_ready=1.
  - A command in flight at reset is discarded, and no consumer sees it afterwards.
- **in_valid low:** the data register holds its value; input data is ignored.

Optional Feature:
- **Macro:** WEIGHT_FANOUT_BOUND_CHECK_EN.
- **Defined:** a command with w_row_index >= MAX_ROW or w_layer_index >= MAX_LAYER is handled as follows.
  - It is still accepted, with in_ready following the same rule.
  - It is not broadcast: pending becomes 0 after the accepting cycle, and the data register and load_count are unchanged.
  - range_err is set and sticky until reset.
- **Undefined:** no range comparison; range_err is tied 0 and all accepted commands are broadcast.

Test Plan:
1. **Reset then single command:** reset, then one command {is_load=1, row=5, layer=2} with out_ready all 1.
   - out_valid=4'b1111 for exactly one cycle, 1 cycle after acceptance.
   - Every copy reads row 5, layer 2.
   - load_count=1.
2. **Staggered ready:** out_ready=0001, then 0110, then 1000, with in_valid held high.
   - pending goes 1111 -> 1110 -> 1000 -> next command.
   - in_ready is high only in the 1000 cycle.
   - No command is lost or duplicated.
3. **Back-to-back streaming:** 8 commands, all ready high.
   - 8 consecutive out_valid cycles with matching data.
   - in_ready stays 1; load_count equals the number of is_load=1 commands.
4. **Saturation:** CNT_W=2, 5 load commands.
   - load_count reads 3 and stays at 3.
5. **Reset mid-drain:** reset while pending=0101.
   - Outputs go to 0 immediately (async).
   - After release, out_valid=0 until the next transfer.
6. **Bound check (macro defined):** command with row=1024, MAX_ROW=1024.
   - Accepted, no out_valid, range_err=1 and stays 1.
   - A following valid command with row=3 broadcasts normally.
